// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// Serves the MEM-stage 32-bit load/store request from an external 16-bit
// asynchronous SRAM. Each request becomes two half-word accesses: the low
// half-word first, then the high half-word. Each access lasts WAIT_CYCLES
// cycles. While a request is in flight, ready is held low. The pipeline
// uses ~ready as the freeze signal for all stage registers.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   wr_en      store request; the CPU holds it until ready=1
//   rd_en      load request; the CPU holds it until ready=1
//   address    word-aligned CPU byte address (the ALU result)
//   wdata      store data
//   rdata      load data; valid in the ready=1 cycle that ends a read
//   ready      1 = done or idle, 0 = freeze the pipeline
//   SRAM_DQ    bidirectional SRAM data bus; driven only while SRAM_WE_N=0
//   SRAM_ADDR  SRAM half-word address
//   SRAM_WE_N  SRAM write enable, active low
// -----------------------------------------------------------------------------
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SRAM_AW-1:0]   lo_q, lo_d;
  logic [SRAM_AW-1:0]   hi_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic                 we_n_q, we_n_d;
  logic [15:0]          dq_out_q, dq_out_d;

  logic [31:0]          off_s;
  logic [SRAM_AW-1:0]   lo_s;
  logic                 last_s;
  logic                 ready_s;
  logic                 addr_unused_s;

  // CPU byte address -> SRAM half-word pair. The offset wraps modulo 2^32.
  assign off_s  = address - 32'(BASE_ADDR);
  assign lo_s   = {off_s[SRAM_AW:2], 1'b0};
  assign last_s = (cnt_q == CNT_LAST);

  // Byte-lane bits and bits above the SRAM window do not select a location.
  assign addr_unused_s = ^{off_s[31:SRAM_AW+1], off_s[1:0]};

  // Next state, wait counter, request capture and read-data latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        ready_s = ~(wr_en | rd_en);
        cnt_d   = {CW{1'b0}};
        if (wr_en) begin
          // A write takes priority. A simultaneous read is dropped.
          state_d = WR_LO;
          lo_d    = lo_s;
          wdata_d = wdata;
        end else if (rd_en) begin
          state_d = RD_LO;
          lo_d    = lo_s;
        end else begin
          state_d = IDLE;
        end
      end
      WR_LO: begin
        if (last_s) begin
          state_d = WR_HI;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_HI: begin
        if (last_s) begin
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_LO: begin
        if (last_s) begin
          // Sample at the end of the phase, after the full SRAM access time.
          rdata_d[15:0] = SRAM_DQ;
          state_d       = RD_HI;
          cnt_d         = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_HI: begin
        if (last_s) begin
          rdata_d[31:16] = SRAM_DQ;
          state_d        = DONE;
          cnt_d          = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ready_s = 1'b1;
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // SRAM pin values are decoded from the next state so that the registered
  // pins change on the same edge as the state. Write enable and the data
  // drive come from one flop pair, so DQ is released in the same cycle
  // that WE_N rises.
  always_comb begin
    hi_d        = lo_d + SRAM_AW'(1);
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    dq_out_d    = dq_out_q;
    case (state_d)
      WR_LO: begin
        sram_addr_d = lo_d;
        we_n_d      = 1'b0;
        dq_out_d    = wdata_d[15:0];
      end
      WR_HI: begin
        sram_addr_d = hi_d;
        we_n_d      = 1'b0;
        dq_out_d    = wdata_d[31:16];
      end
      RD_LO: begin
        sram_addr_d = lo_d;
      end
      RD_HI: begin
        sram_addr_d = hi_d;
      end
      default: begin
        sram_addr_d = sram_addr_q;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      lo_q        <= {SRAM_AW{1'b0}};
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      sram_addr_q <= {SRAM_AW{1'b0}};
      we_n_q      <= 1'b1;
      dq_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_s;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = we_n_q ? 16'bz : dq_out_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Bench for sram_mem_controller with a behavioural 16-bit SRAM model.
// Directed requests push their expected completion into a scoreboard queue.
// A monitor pops an entry each time a held request completes (ready=1 while
// a request is asserted). It then checks rdata, the freeze latency and the
// number of write-enable cycles.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

  localparam int W   = 2;
  localparam int LAT = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  sram_mem_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model. It drives the bus only while the controller is not writing.
  // Words 0..15 are preloaded with 0x1000+i while reset is held at start-up.
  logic [15:0] mem [0:262143];
  logic [3:0]  init_idx = 4'd0;
  logic        preload_en = 1'b1;

  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] <= sram_dq;
    end else if (preload_en && !rst) begin
      mem[18'(init_idx)] <= 16'h1000 + 16'(init_idx);
      init_idx <= init_idx + 4'd1;
    end
  end

  typedef struct {
    logic        is_rd;
    logic [31:0] exp_rdata;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: counts the freeze and write-enable cycles of each held request
  // and checks the completion against the next scoreboard entry.
  initial begin
    int   lat;
    int   wel;
    exp_t e;
    lat = 0;
    wel = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        lat = 0;
        wel = 0;
      end else if (wr_en || rd_en) begin
        if (!sram_we_n) wel++;
        if (!ready) begin
          lat++;
        end else begin
          if (sb_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_ready: completion with empty scoreboard");
          end else begin
            e = sb_q.pop_front();
            chk("rdata", rdata, e.exp_rdata);
            chk("latency", 32'(lat), 32'(LAT));
            chk("we_low_cycles", 32'(wel), e.is_rd ? 32'd0 : 32'(2 * W));
          end
          lat = 0;
          wel = 0;
        end
      end
    end
  end

  // Issue one request and hold it until completion. Must be called just
  // after a rising edge; returns just after the rising edge that follows
  // the completion cycle.
  task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_r);
    bit done;
    sb_q.push_back('{is_rd: (rd && !wr), exp_rdata: exp_r});
    wr_en   = wr;
    rd_en   = rd;
    address = a;
    wdata   = d;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
    end
    if (!done) begin
      total++;
      $display("FAIL timeout: no ready for request at 0x%08h", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with the SRAM model preloading during reset.
    repeat (20) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    preload_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: write 0xDEADBEEF to 1024.
    do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0);
    idle_cycle();
    chk("t1_mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("t1_mem1", 32'(mem[1]), 32'h0000DEAD);

    // 2: read it back.
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF);
    idle_cycle();

    // 3: idle for 10 cycles. The bus must carry only the SRAM's own value.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_ready", 32'(ready), 32'd1);
      chk("t3_we_n", 32'(sram_we_n), 32'd1);
      chk("t3_dq_undriven", 32'(sram_dq), 32'(mem[sram_addr]));
    end
    @(posedge clk);
    #1;

    // 4: back-to-back write then read at 1028.
    do_req(1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'd1028, 32'd0, 32'h12345678);
    idle_cycle();
    chk("t4_mem2", 32'(mem[2]), 32'h00005678);
    chk("t4_mem3", 32'(mem[3]), 32'h00001234);
    chk("t4_mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("t4_mem1", 32'(mem[1]), 32'h0000DEAD);

    // 5: reset during WR_HI (cycle 3) of a write to 1040 (SRAM words 8/9).
    wr_en   = 1'b1;
    address = 32'd1040;
    wdata   = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_in_wr_hi_we_n", 32'(sram_we_n), 32'd0);
    chk("t5_in_wr_hi_addr", 32'(sram_addr), 32'd9);
    rst = 1'b0;
    #1;
    chk("t5_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("t5_rst_rdata", rdata, 32'd0);
    chk("t5_rst_addr", 32'(sram_addr), 32'd0);
    chk("t5_rst_ready_req", 32'(ready), 32'd0);
    chk("t5_rst_dq_undriven", 32'(sram_dq), 32'(mem[sram_addr]));
    wr_en = 1'b0;
    #1;
    chk("t5_rst_ready_idle", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_mem8_written", 32'(mem[8]), 32'h0000F00D);
    chk("t5_mem9_aborted", 32'(mem[9]), 32'h00001009);

    // 6: simultaneous write and read. The write is served and rdata is unchanged (0 after reset).
    do_req(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'd0);
    idle_cycle();
    chk("t6_mem4", 32'(mem[4]), 32'h00005A5A);
    chk("t6_mem5", 32'(mem[5]), 32'h0000A5A5);
    chk("t6_rdata_kept", rdata, 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
